// File: rtl/vmem_pkg.sv
// Shared constants and state encoding for the video-memory write arbiter.
// Pixel width is fixed at 3 bits; address width and depth are defaults only.
package vmem_pkg;

  localparam int VMEM_ADDRW_DEF   = 16;
  localparam int VMEM_ENTRIES_DEF = 65536;
  localparam int PIX_W            = 3;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/vmem_write_arbiter_if.sv
// Requester handshake, clear control and vmem write bus of the arbiter.
// The slave modport is the arbiter; the master modport is the core/requester side.
interface vmem_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int VMEM_ADDRW = 16
);
  import vmem_pkg::*;

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*VMEM_ADDRW-1:0] req_addr_i;
  logic [NUM_REQ*PIX_W-1:0]      req_data_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic                          clear_i;
  logic [PIX_W-1:0]              clear_color_i;
  logic                          busy_o;
  logic                          done_o;
  logic                          we_o;
  logic [VMEM_ADDRW-1:0]         waddr_o;
  logic [PIX_W-1:0]              wdata_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, clear_i, clear_color_i,
    output req_ready_o, busy_o, done_o, we_o, waddr_o, wdata_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, clear_i, clear_color_i,
    input  req_ready_o, busy_o, done_o, we_o, waddr_o, wdata_o
  );

endinterface

// File: rtl/vmem_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// Produces a one-hot grant, or zero when en is low or nothing is requested.
module vmem_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTRW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTRW-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt
);

  logic [PTRW-1:0] idx;
  logic            found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTRW'((int'(ptr) + i) % NUM_REQ);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vmem_write_arbiter.sv
// Shares the vmem write port among NUM_REQ requesters (round-robin) and runs a
// full-frame clear sequencer that owns the port exclusively while busy.
module vmem_write_arbiter
  import vmem_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int VMEM_ADDRW   = VMEM_ADDRW_DEF,
  parameter int VMEM_ENTRIES = VMEM_ENTRIES_DEF
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  vmem_write_arbiter_if.slave bus
);

  localparam int PTRW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // One extra bit so the terminal count compare never aliases through a wrap.
  localparam int CNTW = VMEM_ADDRW + 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(VMEM_ENTRIES - 1);

  state_e                 state_q, state_d;
  logic [PTRW-1:0]        ptr_q, ptr_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [PIX_W-1:0]       color_q, color_d;
  logic                   we_q, we_d;
  logic [VMEM_ADDRW-1:0]  waddr_q, waddr_d;
  logic [PIX_W-1:0]       wdata_q, wdata_d;
  logic                   done_q, done_d;

  logic                   arb_en;
  logic [NUM_REQ-1:0]     gnt;

  // Grants are suppressed in reset, during a clear, and on the cycle a clear starts.
  assign arb_en = rst_ni && (state_q == ST_ARB) && !bus.clear_i;

  vmem_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTRW    (PTRW)
  ) u_rr (
    .req (bus.req_valid_i),
    .ptr (ptr_q),
    .en  (arb_en),
    .gnt (gnt)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    color_d = color_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        if (bus.clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          color_d = bus.clear_color_i;
        end else begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
              we_d    = 1'b1;
              waddr_d = bus.req_addr_i[i*VMEM_ADDRW +: VMEM_ADDRW];
              wdata_d = bus.req_data_i[i*PIX_W +: PIX_W];
              ptr_d   = (i == NUM_REQ - 1) ? '0 : PTRW'(i + 1);
            end
          end
        end
      end
      ST_CLEAR: begin
        we_d    = 1'b1;
        waddr_d = cnt_q[VMEM_ADDRW-1:0];
        wdata_d = color_q;
        cnt_d   = cnt_q + CNTW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_ARB;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      cnt_q   <= '0;
      color_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      color_q <= color_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
    end
  end

  assign bus.req_ready_o = gnt;
  assign bus.busy_o      = (state_q == ST_CLEAR);
  assign bus.done_o      = done_q;
  assign bus.we_o        = we_q;
  assign bus.waddr_o     = waddr_q;
  assign bus.wdata_o     = wdata_q;

endmodule

// File: tb/tb_vmem_write_arbiter.sv
// Scoreboard bench: a small arbiter/clear model predicts ready, busy and done,
// and queues expected vmem writes that are popped as the DUT emits them.
module tb_vmem_write_arbiter;
  import vmem_pkg::*;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int NE = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vmem_write_arbiter_if #(.NUM_REQ(NR), .VMEM_ADDRW(AW)) bus ();

  vmem_write_arbiter #(
    .NUM_REQ      (NR),
    .VMEM_ADDRW   (AW),
    .VMEM_ENTRIES (NE)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [NR-1:0] valid;
  logic [AW-1:0] addr [NR];
  logic [2:0]    data [NR];

  always_comb begin
    bus.req_valid_i = valid;
    bus.req_addr_i  = '0;
    bus.req_data_i  = '0;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr_i[i*AW +: AW] = addr[i];
      bus.req_data_i[i*3 +: 3]   = data[i];
    end
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [2:0]    data;
  } wr_t;

  wr_t sb[$];

  int n_vec  = 0;
  int n_miss = 0;
  int m_ptr  = 0;
  int m_left = 0;
  int gnt_idx = -1;
  int n_done = 0;
  bit m_busy = 1'b0;
  bit m_done = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    logic [NR-1:0] er;
    int w;
    wr_t e;
    @(negedge clk);
    if (bus.we_o) begin
      if (sb.size() == 0) begin
        chk("we_unexpected", 32'(bus.we_o), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("waddr", 32'(bus.waddr_o), 32'(e.addr));
        chk("wdata", 32'(bus.wdata_o), 32'(e.data));
      end
    end
    if (bus.done_o) n_done++;
    chk("busy", 32'(bus.busy_o), 32'(m_busy));
    chk("done", 32'(bus.done_o), 32'(m_done));
    w = -1;
    if (!m_busy && !bus.clear_i) begin
      for (int i = 0; i < NR; i++) begin
        int k;
        k = (m_ptr + i) % NR;
        if (w < 0 && valid[k]) w = k;
      end
    end
    er = (w >= 0) ? (NR'(1) << w) : '0;
    chk("ready", 32'(bus.req_ready_o), 32'(er));
    gnt_idx = w;
    m_done = 1'b0;
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else if (bus.clear_i) begin
      m_busy = 1'b1;
      m_left = NE;
      for (int a = 0; a < NE; a++) sb.push_back('{addr: AW'(a), data: bus.clear_color_i});
    end else if (w >= 0) begin
      sb.push_back('{addr: addr[w], data: data[w]});
      m_ptr = (w + 1) % NR;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit drop);
    for (int c = 0; c < n; c++) begin
      tick();
      if (gnt_idx >= 0) begin
        if (drop) valid[gnt_idx] = 1'b0;
        else begin
          addr[gnt_idx] = AW'($urandom);
          data[gnt_idx] = 3'($urandom);
        end
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    sb.delete();
    m_ptr = 0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    #1;
    chk("rst_we_now", 32'(bus.we_o), 32'd0);
    chk("rst_busy_now", 32'(bus.busy_o), 32'd0);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      valid = NR'($urandom);
      bus.clear_i = 1'($urandom);
      bus.clear_color_i = 3'($urandom);
      for (int i = 0; i < NR; i++) begin
        addr[i] = AW'($urandom);
        data[i] = 3'($urandom);
      end
      @(negedge clk);
      chk("rst_we", 32'(bus.we_o), 32'd0);
      chk("rst_busy", 32'(bus.busy_o), 32'd0);
      chk("rst_done", 32'(bus.done_o), 32'd0);
      chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
    end
    @(posedge clk); #1;
    valid = '0;
    bus.clear_i = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    valid = '0;
    for (int i = 0; i < NR; i++) begin
      addr[i] = '0;
      data[i] = '0;
    end
    bus.clear_i = 1'b0;
    bus.clear_color_i = '0;
    #2;

    // reset, then a lone request from requester 2
    do_reset(4);
    valid = 4'b0100; addr[2] = 8'h5A; data[2] = 3'd6;
    tick();
    valid[2] = 1'b0;
    run(2, 1'b1);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // round-robin with all four holding valid, pointer starting at 0
    do_reset(1);
    for (int i = 0; i < NR; i++) begin
      addr[i] = AW'($urandom);
      data[i] = 3'($urandom);
    end
    valid = 4'hF;
    run(8, 1'b0);
    valid = '0;
    run(2, 1'b1);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);

    // full clear with colour 5
    n_done = 0;
    bus.clear_i = 1'b1; bus.clear_color_i = 3'b101;
    tick();
    bus.clear_i = 1'b0;
    run(20, 1'b1);
    chk("t3_done_cnt", 32'(n_done), 32'd1);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);

    // clear collides with requests 0 and 1
    n_done = 0;
    valid = 4'b0011; addr[0] = 8'h11; data[0] = 3'd1; addr[1] = 8'h22; data[1] = 3'd2;
    bus.clear_i = 1'b1; bus.clear_color_i = 3'd2;
    tick();
    bus.clear_i = 1'b0;
    run(22, 1'b1);
    chk("t4_done_cnt", 32'(n_done), 32'd1);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // reset in the middle of a clear, then a complete clear
    bus.clear_i = 1'b1; bus.clear_color_i = 3'd7;
    tick();
    bus.clear_i = 1'b0;
    run(8, 1'b1);
    chk("t5_we_before_rst", 32'(bus.we_o), 32'd1);
    n_done = 0;
    do_reset(2);
    chk("t5_no_done", 32'(n_done), 32'd0);
    bus.clear_i = 1'b1; bus.clear_color_i = 3'd3;
    tick();
    bus.clear_i = 1'b0;
    run(20, 1'b1);
    chk("t5_done_cnt", 32'(n_done), 32'd1);
    chk("t5_sb_empty", 32'(sb.size()), 32'd0);

    // re-trigger during a clear is ignored
    n_done = 0;
    bus.clear_i = 1'b1; bus.clear_color_i = 3'd4;
    tick();
    bus.clear_i = 1'b0;
    run(5, 1'b1);
    bus.clear_i = 1'b1; bus.clear_color_i = 3'd1;
    tick();
    bus.clear_i = 1'b0;
    run(20, 1'b1);
    chk("t6_done_cnt", 32'(n_done), 32'd1);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
